// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract split into STAGES carry segments, one segment per clock.
// Latency: STAGES cycles from accept to out_valid, one result per cycle when not stalled.
// Backpressure: whole pipe advances only when !out_valid || out_ready; in_ready mirrors that.
//
// Ports:
//   clk, rst_n              rising-edge clock, synchronous active-low reset
//   in_valid/in_ready       operand handshake (a, b, c_in, sub, tag)
//   out_valid/out_ready     result handshake (sum, c_out, ovf, out_tag)
//   sat                     saturate request, present only when PADDER_SAT_EN is defined
//
// Build option: define PADDER_SAT_EN to add the sat port and signed saturation on overflow.
module pipelined_adder #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic [TAG_W-1:0] out_tag
`ifdef PADDER_SAT_EN
    ,
    input  logic             sat
`endif
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;
    localparam int MSB  = WIDTH - 1;

    // Per-stage registers. Operands are kept full width so every stage can
    // index its own segment with the same expression; segments already
    // consumed are simply never read again.
    logic             vld_q  [STAGES];
    logic [WIDTH-1:0] a_q    [STAGES];
    logic [WIDTH-1:0] bx_q   [STAGES];
    logic [WIDTH-1:0] sum_q  [STAGES];
    logic             cy_q   [STAGES];
    logic [TAG_W-1:0] tag_q  [STAGES];
    logic             ovf_q;
`ifdef PADDER_SAT_EN
    logic             sat_q  [STAGES];
`endif

    // Stage inputs: index 0 comes from the ports, index k from stage k-1.
    logic             src_vld [STAGES];
    logic [WIDTH-1:0] src_a   [STAGES];
    logic [WIDTH-1:0] src_bx  [STAGES];
    logic [WIDTH-1:0] src_sum [STAGES];
    logic             src_cy  [STAGES];
    logic [TAG_W-1:0] src_tag [STAGES];
`ifdef PADDER_SAT_EN
    logic             src_sat [STAGES];
`endif

    logic [WIDTH-1:0] nxt_sum [STAGES];
    logic             nxt_cy  [STAGES];
    logic             nxt_ovf;
    logic [SEG:0]     seg;
    logic             adv;

    always_comb begin
        adv = !vld_q[LAST] || out_ready;

        // Subtraction is a + ~b + 1; c_in only matters in add mode.
        src_vld[0] = in_valid;
        src_a[0]   = a;
        src_bx[0]  = sub ? ~b : b;
        src_cy[0]  = sub ? 1'b1 : c_in;
        src_sum[0] = '0;
        src_tag[0] = tag;
`ifdef PADDER_SAT_EN
        src_sat[0] = sat;
`endif
        for (int k = 1; k < STAGES; k++) begin
            src_vld[k] = vld_q[k-1];
            src_a[k]   = a_q[k-1];
            src_bx[k]  = bx_q[k-1];
            src_cy[k]  = cy_q[k-1];
            src_sum[k] = sum_q[k-1];
            src_tag[k] = tag_q[k-1];
`ifdef PADDER_SAT_EN
            src_sat[k] = sat_q[k-1];
`endif
        end

        seg = '0;
        for (int k = 0; k < STAGES; k++) begin
            seg = {1'b0, src_a[k][k*SEG +: SEG]}
                + {1'b0, src_bx[k][k*SEG +: SEG]}
                + {{SEG{1'b0}}, src_cy[k]};
            // Lower segments finished by earlier stages ride along unchanged.
            nxt_sum[k]                = src_sum[k];
            nxt_sum[k][k*SEG +: SEG]  = seg[SEG-1:0];
            nxt_cy[k]                 = seg[SEG];
        end

        // Signed overflow: operands share a sign but the sum does not.
        nxt_ovf = (src_a[LAST][MSB] == src_bx[LAST][MSB])
               && (nxt_sum[LAST][MSB] != src_a[LAST][MSB]);

`ifdef PADDER_SAT_EN
        // On overflow the true result's sign is a's sign: clamp towards it.
        if (src_sat[LAST] && nxt_ovf) begin
            nxt_sum[LAST] = src_a[LAST][MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                                             : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                a_q[k]   <= '0;
                bx_q[k]  <= '0;
                sum_q[k] <= '0;
                cy_q[k]  <= 1'b0;
                tag_q[k] <= '0;
`ifdef PADDER_SAT_EN
                sat_q[k] <= 1'b0;
`endif
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= src_vld[k];
                a_q[k]   <= src_a[k];
                bx_q[k]  <= src_bx[k];
                sum_q[k] <= nxt_sum[k];
                cy_q[k]  <= nxt_cy[k];
                tag_q[k] <= src_tag[k];
`ifdef PADDER_SAT_EN
                sat_q[k] <= src_sat[k];
`endif
            end
            ovf_q <= nxt_ovf;
        end
    end

    assign in_ready  = adv;
    assign out_valid = vld_q[LAST];
    assign sum       = sum_q[LAST];
    assign c_out     = cy_q[LAST];
    assign ovf       = ovf_q;
    assign out_tag   = tag_q[LAST];

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed and randomized checks of pipelined_adder (WIDTH=64, STAGES=4).
// Expected results come from a signed/unsigned arithmetic reference model and a result queue.
// Inputs change 1 ns after the rising edge; outputs are sampled 3 ns after it.
module tb_pipelined_adder;

    localparam int WIDTH  = 64;
    localparam int STAGES = 4;
    localparam int TAG_W  = 4;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] SMAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] SMIN = 64'h8000_0000_0000_0000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             c_in = 1'b0;
    logic             sub = 1'b0;
    logic [TAG_W-1:0] tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    logic [TAG_W-1:0] out_tag;
    logic             sat = 1'b0;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub), .tag(tag),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .c_out(c_out),
        .ovf(ovf), .out_tag(out_tag)
`ifdef PADDER_SAT_EN
        , .sat(sat)
`endif
    );

    typedef struct {
        logic [63:0] s;
        logic        co;
        logic        ov;
        logic [3:0]  tg;
        int          acyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    // Per-cycle observations (taken before the edge that may transfer them).
    bit          seen_out;
    bit          acc;
    logic [63:0] o_sum;
    logic        o_co, o_ov, o_rdy;
    logic [3:0]  o_tag;
    int          o_cyc;

    // Reference: exact signed result compared with the 64-bit signed range.
    function automatic exp_t model(input logic [63:0] av, input logic [63:0] bv,
                                   input logic ci, input logic sb, input logic st,
                                   input logic [3:0] tg);
        exp_t e;
        logic [64:0] full;
        logic signed [65:0] r, sa, sbv, smaxw, sminw;
        sa    = {{2{av[63]}}, av};
        sbv   = {{2{bv[63]}}, bv};
        smaxw = {2'b00, SMAX};
        sminw = {2'b11, SMIN};
        if (sb) begin
            e.s  = av - bv;
            e.co = (av >= bv);
            r    = sa - sbv;
        end else begin
            full = {1'b0, av} + {1'b0, bv} + {64'd0, ci};
            e.s  = full[63:0];
            e.co = full[64];
            r    = sa + sbv + $signed({65'd0, ci});
        end
        e.ov = (r > smaxw) || (r < sminw);
`ifdef PADDER_SAT_EN
        if (st && e.ov) e.s = (r > 0) ? SMAX : SMIN;
`else
        if (st && 1'b0) e.s = '0;
`endif
        e.tg   = tg;
        e.acyc = 0;
        return e;
    endfunction

    // Advance one clock, recording what the bench saw and what was accepted.
    task automatic cycle();
        exp_t e;
        #2;
        seen_out = (out_valid === 1'b1) && out_ready;
        o_sum = sum; o_co = c_out; o_ov = ovf; o_tag = out_tag; o_rdy = in_ready;
        o_cyc = cyc;
        acc = (in_valid === 1'b1) && (in_ready === 1'b1) && (rst_n === 1'b1);
        if (acc) begin
            e = model(a, b, c_in, sub, sat, tag);
            e.acyc = cyc;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_n) q.delete();
    endtask

    // Wait (bounded) for the next delivered result; returns its expectation.
    task automatic collect(input int budget, output bit got, output exp_t e, output int lat);
        got = 0; lat = -1;
        e.s = 'x; e.co = 1'bx; e.ov = 1'bx; e.tg = 'x; e.acyc = 0;
        for (int i = 0; i < budget && !got; i++) begin
            cycle();
            if (seen_out) begin
                got = 1;
                if (q.size() > 0) begin
                    e = q.pop_front();
                    lat = o_cyc - e.acyc;
                end
            end
        end
    endtask

    task automatic rand_op(input logic [3:0] tg);
        case ($urandom_range(0, 3))
            0: a = ONES;
            1: a = SMAX;
            default: a = {$urandom(), $urandom()};
        endcase
        b    = ($urandom_range(0, 3) == 0) ? 64'd1 : {$urandom(), $urandom()};
        c_in = 1'($urandom_range(0, 1));
        sub  = 1'($urandom_range(0, 1));
        sat  = 1'($urandom_range(0, 1));
        tag  = tg;
    endtask

    task automatic test_reset();
        rst_n = 0; in_valid = 0; out_ready = 1;
        cycle(); cycle();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_tests++; if (sum !== 64'd0) begin n_fail++; $display("FAIL reset_sum got=%h exp=0", sum); end
        n_tests++; if (c_out !== 1'b0) begin n_fail++; $display("FAIL reset_c_out got=%b exp=0", c_out); end
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        n_tests++; if (out_tag !== 4'd0) begin n_fail++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
        rst_n = 1;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_carry_ripple();
        bit got; exp_t e; int lat;
        a = ONES; b = 64'd0; c_in = 1; sub = 0; sat = 0; tag = 4'hA; in_valid = 1;
        cycle();
        in_valid = 0;
        collect(12, got, e, lat);
        n_tests++; if (!got) begin n_fail++; $display("FAIL ripple_timeout got=none exp=result"); end
        n_tests++; if (o_sum !== 64'd0) begin n_fail++; $display("FAIL ripple_sum got=%h exp=0", o_sum); end
        n_tests++; if (o_co !== 1'b1) begin n_fail++; $display("FAIL ripple_c_out got=%b exp=1", o_co); end
        n_tests++; if (o_ov !== 1'b0) begin n_fail++; $display("FAIL ripple_ovf got=%b exp=0", o_ov); end
        n_tests++; if (o_tag !== 4'hA) begin n_fail++; $display("FAIL ripple_tag got=%h exp=a", o_tag); end
        n_tests++; if (lat !== STAGES) begin n_fail++; $display("FAIL ripple_latency got=%0d exp=%0d", lat, STAGES); end
    endtask

    task automatic test_sub();
        bit got; exp_t e; int lat;
        a = 64'd5; b = 64'd7; c_in = 0; sub = 1; sat = 0; tag = 4'd1; in_valid = 1;
        cycle();
        a = SMIN; b = 64'd1; c_in = 0; tag = 4'd2;
        cycle();
        in_valid = 0;
        collect(12, got, e, lat);
        n_tests++; if (!got || o_sum !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL sub1_sum got=%h exp=fffffffffffffffe", o_sum); end
        n_tests++; if (o_co !== 1'b0 || o_ov !== 1'b0) begin n_fail++; $display("FAIL sub1_flags got=co%b/ov%b exp=co0/ov0", o_co, o_ov); end
        n_tests++; if (o_tag !== 4'd1) begin n_fail++; $display("FAIL sub1_tag got=%h exp=1", o_tag); end
        collect(12, got, e, lat);
        n_tests++; if (!got || o_sum !== SMAX) begin n_fail++; $display("FAIL sub2_sum got=%h exp=%h", o_sum, SMAX); end
        n_tests++; if (o_co !== 1'b1 || o_ov !== 1'b1) begin n_fail++; $display("FAIL sub2_flags got=co%b/ov%b exp=co1/ov1", o_co, o_ov); end
        n_tests++; if (o_tag !== 4'd2) begin n_fail++; $display("FAIL sub2_tag got=%h exp=2", o_tag); end
    endtask

    task automatic test_stream();
        exp_t e; int n_out = 0;
        out_ready = 1;
        for (int i = 0; i < 60 && n_out < 16; i++) begin
            if (i < 16) begin rand_op(4'(i)); in_valid = 1; end
            else in_valid = 0;
            cycle();
            if (i < 16) begin
                n_tests++; if (o_rdy !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, o_rdy); end
            end
            if (seen_out) begin
                e = (q.size() > 0) ? q.pop_front() : '{64'hx, 1'bx, 1'bx, 4'hx, -99};
                n_tests++;
                if (o_sum !== e.s || o_co !== e.co || o_ov !== e.ov || o_tag !== 4'(n_out) || o_cyc - e.acyc != STAGES) begin
                    n_fail++;
                    $display("FAIL stream_result[%0d] got=%h/%b/%b/t%h/lat%0d exp=%h/%b/%b/t%h/lat%0d",
                             n_out, o_sum, o_co, o_ov, o_tag, o_cyc - e.acyc, e.s, e.co, e.ov, 4'(n_out), STAGES);
                end
                n_out++;
            end
        end
        n_tests++; if (n_out != 16) begin n_fail++; $display("FAIL stream_count got=%0d exp=16", n_out); end
    endtask

    task automatic test_backpressure();
        exp_t e; int sent = 0, recv = 0;
        logic [63:0] snap_sum; logic snap_co, snap_ov; logic [3:0] snap_tag;
        snap_sum = '0; snap_co = 0; snap_ov = 0; snap_tag = '0;
        rand_op(4'd0);
        for (int i = 0; i < 100 && recv < 12; i++) begin
            out_ready = !(i >= 6 && i < 11);
            in_valid  = (sent < 12);
            cycle();
            if (i >= 6 && i < 11) begin
                n_tests++; if (o_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, o_rdy); end
                if (i == 6) begin
                    snap_sum = o_sum; snap_co = o_co; snap_ov = o_ov; snap_tag = o_tag;
                end else begin
                    n_tests++;
                    if ({o_sum, o_co, o_ov, o_tag} !== {snap_sum, snap_co, snap_ov, snap_tag}) begin
                        n_fail++; $display("FAIL bp_frozen[%0d] got=%h/t%h exp=%h/t%h", i, o_sum, o_tag, snap_sum, snap_tag);
                    end
                end
            end
            if (acc) begin sent++; rand_op(4'(sent)); end
            if (seen_out) begin
                e = (q.size() > 0) ? q.pop_front() : '{64'hx, 1'bx, 1'bx, 4'hx, 0};
                n_tests++;
                if (o_sum !== e.s || o_co !== e.co || o_ov !== e.ov || o_tag !== 4'(recv)) begin
                    n_fail++;
                    $display("FAIL bp_result[%0d] got=%h/%b/%b/t%h exp=%h/%b/%b/t%h",
                             recv, o_sum, o_co, o_ov, o_tag, e.s, e.co, e.ov, 4'(recv));
                end
                recv++;
            end
        end
        in_valid = 0; out_ready = 1;
        n_tests++; if (recv != 12 || q.size() != 0) begin n_fail++; $display("FAIL bp_count got=%0d/left%0d exp=12/left0", recv, q.size()); end
    endtask

    task automatic test_reset_midflight();
        bit got; exp_t e; int lat;
        out_ready = 1;
        for (int i = 1; i <= 3; i++) begin rand_op(4'(i)); in_valid = 1; cycle(); end
        in_valid = 0; rst_n = 0;
        cycle();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid got=%b exp=0", out_valid); end
        n_tests++; if ({sum, c_out, ovf, out_tag} !== '0) begin n_fail++; $display("FAIL rst_mid_outputs got=%h/%b/%b/t%h exp=0", sum, c_out, ovf, out_tag); end
        rst_n = 1;
        a = 64'd1; b = 64'd2; c_in = 0; sub = 0; sat = 0; tag = 4'd9; in_valid = 1;
        cycle();
        in_valid = 0;
        collect(12, got, e, lat);
        n_tests++; if (!got || o_tag !== 4'd9) begin n_fail++; $display("FAIL rst_mid_first_tag got=%h exp=9", o_tag); end
        n_tests++; if (o_sum !== 64'd3) begin n_fail++; $display("FAIL rst_mid_sum got=%h exp=3", o_sum); end
        n_tests++; if (lat !== STAGES) begin n_fail++; $display("FAIL rst_mid_latency got=%0d exp=%0d", lat, STAGES); end
    endtask

`ifdef PADDER_SAT_EN
    task automatic test_sat();
        bit got; exp_t e; int lat;
        out_ready = 1;
        a = SMAX; b = 64'd1; c_in = 0; sub = 0; sat = 1; tag = 4'd5; in_valid = 1;
        cycle();
        sat = 0; tag = 4'd6;
        cycle();
        in_valid = 0;
        collect(12, got, e, lat);
        n_tests++; if (!got || o_sum !== SMAX || o_ov !== 1'b1) begin n_fail++; $display("FAIL sat_on got=%h/ov%b exp=%h/ov1", o_sum, o_ov, SMAX); end
        collect(12, got, e, lat);
        n_tests++; if (!got || o_sum !== SMIN || o_ov !== 1'b1) begin n_fail++; $display("FAIL sat_off got=%h/ov%b exp=%h/ov1", o_sum, o_ov, SMIN); end
    endtask
`endif

    initial begin
        test_reset();
        test_carry_ripple();
        test_sub();
        test_stream();
        test_backpressure();
        test_reset_midflight();
`ifdef PADDER_SAT_EN
        test_sat();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the team's flat 64-bit ripple adder.
- Splits a WIDTH-bit add/subtract into STAGES carry-segments, one segment per clock, and registers the carry between stages.
- Carries a valid/ready handshake on input and output, so it drops into the ALU datapath with back-pressure and one result per cycle.
- Adds subtract mode, signed overflow and result tagging, which the flat adder does not have.

Parameters:
- WIDTH, 64, operand/sum width in bits; must be divisible by STAGES.
- STAGES, 4, pipeline depth and number of carry segments; 1 <= STAGES <= WIDTH. Segment width is SEG = WIDTH/STAGES.
- TAG_W, 4, width of the user tag passed through alongside each operation.

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, reset. Synchronous, active-low.
- in_valid, in, 1, operands present.
- in_ready, out, 1, adder accepts operands this cycle.
- a, in, WIDTH, operand A.
- b, in, WIDTH, operand B.
- c_in, in, 1, carry-in, used in add mode only.
- sub, in, 1, 1 = compute a - b.
- tag, in, TAG_W, opaque tag, returned with the result.
- out_valid, out, 1, result present.
- out_ready, in, 1, downstream accepts the result.
- sum, out, WIDTH, result.
- c_out, out, 1, unsigned carry-out of the top segment.
- ovf, out, 1, signed two's-complement overflow.
- out_tag, out, TAG_W, tag of the result.
- sat, in, 1, saturate request; port exists only when PADDER_SAT_EN is defined.

Behaviour:
- Reset: when rst_n = 0 at a clock edge, all stage valid bits clear. out_valid=0, sum=0, c_out=0, ovf=0, out_tag=0. in_ready=1 in the first cycle after reset. Reset mid-operation discards every in-flight operation with no output.
- Global advance: adv = !out_valid || out_ready. in_ready = adv. The whole pipeline shifts only when adv=1; otherwise every stage register holds. No bubble collapsing.
- Accept: a transfer occurs when in_valid && in_ready. An input with in_valid=1 and in_ready=0 is not captured; upstream must hold it.
- Effective operands:
  - Add: bx = b, cin = c_in.
  - Sub: bx = ~b, cin = 1; c_in is ignored.
- Stage k (0..STAGES-1) computes segment bits [k*SEG +: SEG] = a_seg + bx_seg + carry_k. carry_0 = cin; carry_{k+1} is registered.
- Skew and deskew:
  - Unconsumed upper segments of a/bx are delayed in registers alongside the operation.
  - Completed lower sum segments are delayed so the full sum emerges aligned.
- Latency: exactly STAGES cycles from accept to out_valid when no stall. Throughput is 1 op/cycle.
- c_out = carry out of segment STAGES-1. In sub mode c_out=1 means no borrow (a >= b unsigned).
- ovf = (a[MSB] == bx[MSB]) && (sum[MSB] != a[MSB]), evaluated in the last stage.
- Wrap-around: results are modulo 2^WIDTH. For example, all-ones + 1 gives sum=0, c_out=1.
- Outputs sum/c_out/ovf/out_tag are registered and hold stable while out_valid && !out_ready.
- Simultaneous events:
  - Output drain and input accept in the same cycle are both honoured; full throughput is preserved with out_ready held high.
  - rst_n=0 overrides any handshake.
- STAGES=1 degenerates to a single registered adder with latency 1.

Optional Feature:
- Macro PADDER_SAT_EN.
- Defined: the port sat exists and travels with its operation. If sat=1 and ovf=1 at the last stage, the result saturates:
  - to 0111..1 when a[MSB]=0;
  - to 1000..0 when a[MSB]=1.
  - ovf is still reported as 1; c_out is unchanged.
- Not defined: the port is absent, no saturation logic is present, and results always wrap.

Test Plan:
1. WIDTH=64, STAGES=4: a=0xFFFFFFFFFFFFFFFF, b=0, c_in=1, sub=0 -> 4 cycles later out_valid=1, sum=0, c_out=1, ovf=0 (carry ripples across all segment boundaries).
2. Sub mode: a=5, b=7 -> sum=0xFFFFFFFFFFFFFFFE, c_out=0, ovf=0. Then a=0x8000000000000000, b=1 -> sum=0x7FFFFFFFFFFFFFFF, ovf=1.
3. Streaming: 16 back-to-back random ops, tags 0..15, out_ready=1 -> in_ready stays 1; results appear in order every cycle after 4-cycle latency and match the a±b reference model.
4. Back-pressure: hold out_ready=0 for 5 cycles while the pipe is full -> in_ready=0, outputs frozen. Release -> no loss or duplication; tag sequence is contiguous.
5. Reset mid-flight: 3 ops accepted, rst_n=0 for 1 cycle -> out_valid=0 with all outputs 0. The next op after reset emerges with correct latency.
6. With PADDER_SAT_EN: a=0x7FFFFFFFFFFFFFFF, b=1, sat=1 -> sum=0x7FFFFFFFFFFFFFFF, ovf=1. Same op with sat=0 -> sum=0x8000000000000000.
